// File: rtl/ext_mem_responder_if.sv
// Request/response bundle between a register block's external port and the
// memory responder. The master drives requests; the slave answers with acks.
interface ext_mem_responder_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  req;
  logic                  req_is_wr;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] wr_biten;
  logic                  rd_ack;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  wr_ack;
  logic                  busy;
  logic [7:0]            drop_cnt;

  modport master (
    output req, req_is_wr, addr, wr_data, wr_biten,
    input  rd_ack, rd_data, wr_ack, busy, drop_cnt
  );

  modport slave (
    input  req, req_is_wr, addr, wr_data, wr_biten,
    output rd_ack, rd_data, wr_ack, busy, drop_cnt
  );
endinterface

// File: rtl/ext_mem_responder.sv
// Small word-addressed memory that answers register-block external requests
// after a fixed latency. One request is outstanding at a time; a request that
// arrives while waiting (and no ack is out that cycle) is dropped and counted.
module ext_mem_responder #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 2
) (
  input  logic               clk,
  input  logic               rst,
  ext_mem_responder_if.slave bus
);

  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam int DEPTH = 2 ** IDX_W;
  localparam logic [3:0] LOAD_VAL = 4'(LATENCY - 1);

  if ((LATENCY < 1) || (LATENCY > 15)) begin : g_bad_latency
    $error("ext_mem_responder: LATENCY must be within 1..15");
  end
  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("ext_mem_responder: only DATA_WIDTH of 32 is supported");
  end

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t                state_r;
  state_t                state_nxt;
  logic [3:0]            cnt_r;
  logic [3:0]            cnt_nxt;
  logic                  cap_wr_r;
  logic [IDX_W-1:0]      cap_idx_r;
  logic [DATA_WIDTH-1:0] cap_data_r;
  logic [DATA_WIDTH-1:0] cap_biten_r;
  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic                  rd_ack_r;
  logic                  wr_ack_r;
  logic [DATA_WIDTH-1:0] rd_data_r;
  logic [7:0]            drop_cnt_r;

  logic                  ack_now_s;
  logic                  accept_s;
  logic                  drop_s;
  logic                  fire_s;
  logic                  eff_wr_s;
  logic [IDX_W-1:0]      eff_idx_s;
  logic [DATA_WIDTH-1:0] eff_data_s;
  logic [DATA_WIDTH-1:0] eff_biten_s;
  logic                  unused_addr_lsbs;

  // Byte-lane bits of the address do not select anything.
  assign unused_addr_lsbs = ^bus.addr[1:0];

  // A new request is taken when idle or in the cycle an ack is being shown.
  assign ack_now_s = rd_ack_r | wr_ack_r;
  assign accept_s  = bus.req & ((state_r == IDLE) | ack_now_s);
  assign drop_s    = bus.req & (state_r == WAIT) & ~ack_now_s;

  // Next state and countdown; the ack is shown while WAIT holds a zero count.
  always_comb begin
    state_nxt = state_r;
    cnt_nxt   = cnt_r;
    if (accept_s) begin
      state_nxt = WAIT;
      cnt_nxt   = LOAD_VAL;
    end else if (state_r == WAIT) begin
      if (cnt_r == 4'd0) begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end else begin
        state_nxt = WAIT;
        cnt_nxt   = cnt_r - 4'd1;
      end
    end else begin
      state_nxt = IDLE;
      cnt_nxt   = 4'd0;
    end
  end

  assign fire_s = (state_nxt == WAIT) && (cnt_nxt == 4'd0);

  // Transaction that completes on this edge: with a one-cycle latency it is
  // the request being accepted right now, otherwise the captured one.
  always_comb begin
    eff_wr_s    = cap_wr_r;
    eff_idx_s   = cap_idx_r;
    eff_data_s  = cap_data_r;
    eff_biten_s = cap_biten_r;
    if (accept_s) begin
      eff_wr_s    = bus.req_is_wr;
      eff_idx_s   = bus.addr[ADDR_WIDTH-1:2];
      eff_data_s  = bus.wr_data;
      eff_biten_s = bus.wr_biten;
    end else begin
      eff_wr_s    = cap_wr_r;
      eff_idx_s   = cap_idx_r;
      eff_data_s  = cap_data_r;
      eff_biten_s = cap_biten_r;
    end
  end

  // State and countdown registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_nxt;
      cnt_r   <= cnt_nxt;
    end
  end

  // Capture the accepted request for the duration of the wait.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_wr_r    <= 1'b0;
      cap_idx_r   <= {IDX_W{1'b0}};
      cap_data_r  <= {DATA_WIDTH{1'b0}};
      cap_biten_r <= {DATA_WIDTH{1'b0}};
    end else if (accept_s) begin
      cap_wr_r    <= bus.req_is_wr;
      cap_idx_r   <= bus.addr[ADDR_WIDTH-1:2];
      cap_data_r  <= bus.wr_data;
      cap_biten_r <= bus.wr_biten;
    end
  end

  // Registered ack pulses; read data is zero whenever no read ack is shown.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ack_r  <= 1'b0;
      wr_ack_r  <= 1'b0;
      rd_data_r <= {DATA_WIDTH{1'b0}};
    end else begin
      rd_ack_r  <= fire_s & ~eff_wr_s;
      wr_ack_r  <= fire_s & eff_wr_s;
      rd_data_r <= (fire_s & ~eff_wr_s) ? mem_r[eff_idx_s] : {DATA_WIDTH{1'b0}};
    end
  end

  // Storage; a write lands on the same edge that raises its ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (fire_s && eff_wr_s) begin
      mem_r[eff_idx_s] <= (mem_r[eff_idx_s] & ~eff_biten_s) | (eff_data_s & eff_biten_s);
    end
  end

  // Saturating count of requests ignored while waiting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt_r <= 8'd0;
    end else if (drop_s && (drop_cnt_r != 8'hFF)) begin
      drop_cnt_r <= drop_cnt_r + 8'd1;
    end
  end

  assign bus.rd_ack   = rd_ack_r;
  assign bus.wr_ack   = wr_ack_r;
  assign bus.rd_data  = rd_data_r;
  assign bus.busy     = (state_r == WAIT);
  assign bus.drop_cnt = drop_cnt_r;

endmodule

// File: doc/ext_mem_responder.md
EXT_MEM_RESPONDER -- requirements
Module: ext_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, byte-address width of the external window (8 words of 32 bits).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width; only 32 is supported.
REQ-003 SHALL have parameter LATENCY, default 2, number of cycles from request to ack; legal range 1..15.
REQ-004 SHALL have port clk, input, 1, sole clock; all logic is rising-edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port req, input, 1, single-cycle request strobe from the regblock external interface.
REQ-007 SHALL have port req_is_wr, input, 1, write when 1, read when 0; qualified by req.
REQ-008 SHALL have port addr, input, ADDR_WIDTH, byte address; word index = addr[ADDR_WIDTH-1:2], addr[1:0] ignored.
REQ-009 SHALL have port wr_data, input, DATA_WIDTH, write data; qualified by req & req_is_wr.
REQ-010 SHALL have port wr_biten, input, DATA_WIDTH, per-bit write enable.
REQ-011 SHALL have port rd_ack, output, 1, single-cycle read completion.
REQ-012 SHALL have port rd_data, output, DATA_WIDTH, read data; valid only with rd_ack, 0 otherwise.
REQ-013 SHALL have port wr_ack, output, 1, single-cycle write completion.
REQ-014 SHALL have port busy, output, 1, high while a request is outstanding (WAIT state).
REQ-015 SHALL have port drop_cnt, output, 8, saturating count of requests dropped while busy.

Function
REQ-016 SHALL hold storage of 2**(ADDR_WIDTH-2) words, each DATA_WIDTH bits.
REQ-017 SHALL implement states IDLE and WAIT; ack generation is a registered pulse, not a state.
REQ-018 SHALL accept req when state is IDLE or when rd_ack/wr_ack is high in that cycle; on accept, capture req_is_wr, word index, wr_data, wr_biten, load countdown with LATENCY-1, and go to WAIT.
REQ-019 In WAIT, SHALL decrement the countdown each cycle; at countdown 0, assert the ack and return to IDLE unless a new request is accepted in that ack cycle.
REQ-020 With LATENCY=1, SHALL assert the ack in the cycle after req, sustaining one transaction per cycle back-to-back.
REQ-021 SHALL apply a write on the clock edge that raises wr_ack: word <= (word & ~biten) | (wr_data & biten).
REQ-022 SHALL drive rd_data from the storage word on the edge that raises rd_ack; a read reflects all writes acked earlier.
REQ-023 SHALL never assert rd_ack and wr_ack together; each is high exactly one cycle per accepted request.
REQ-024 SHALL ignore req in WAIT when no ack is high that cycle; such a req gets no ack and increments drop_cnt, saturating at 255.
REQ-025 SHALL keep busy = (state == WAIT).
REQ-026 SHALL treat LATENCY outside 1..15 as an elaboration error.

Reset
REQ-027 SHALL, on rst low and independent of clk: clear all storage words to 0, state to IDLE, countdown to 0, rd_ack=0, wr_ack=0, rd_data=0, busy=0, drop_cnt=0.
REQ-028 SHALL abandon any outstanding request on reset with no ack after release; a req in the first cycle after release is accepted normally.

Verification
REQ-029 Write then read, LATENCY=2: req wr addr=0x04, data=0xDEADBEEF, biten=0xFFFFFFFF at cycle 0 -> wr_ack at cycle 2; read addr=0x04 -> rd_ack 2 cycles later with rd_data=0xDEADBEEF.
REQ-030 Partial write: word 0x10 = 0x11223344; write 0xAABBCCDD with biten=0x0000FFFF -> read returns 0x1122CCDD.
REQ-031 Back-to-back, LATENCY=1: reads at cycles 0,1,2 to words 0,1,2 -> rd_ack high at cycles 1,2,3 with matching data; busy never drops, drop_cnt=0.
REQ-032 Drop, LATENCY=3: req at cycle 0 and again at cycle 1 -> one ack at cycle 3, drop_cnt=1; 300 drops -> drop_cnt=255.
REQ-033 Reset mid-operation: write accepted, rst low before ack -> no wr_ack after release, word reads 0, drop_cnt=0.
REQ-034 Address aliasing: write 0x5A5A5A5A to addr 0x07 -> read at addr 0x04 returns 0x5A5A5A5A; rd_data=0 whenever rd_ack=0.
